// File: rtl/fp_pkg.sv
// Shared floating-point constants and FSM state encoding for the
// integer/double conversion datapaths.
package fp_pkg;

   localparam int FP_EXP_BIAS = 1023;
   localparam int FP_EXP_W    = 11;
   localparam int FP_FRAC_W   = 52;
   localparam int FP_W        = 64;
   localparam int INT_W       = 64;

   typedef enum logic [1:0] {
      IDLE,
      NORM,
      ROUND,
      DONE
   } state_e;

endpackage

// File: rtl/fp_composer.sv
// Packs sign, biased exponent and fraction into an IEEE-754 double.
// Combinational counterpart of fp_decomposer.
module fp_composer
   import fp_pkg::*;
(
   input  logic                 sign_i,
   input  logic [FP_EXP_W-1:0]  exp_i,
   input  logic [FP_FRAC_W-1:0] frac_i,
   output logic [FP_W-1:0]      fp_o
);

   assign fp_o = {sign_i, exp_i, frac_i};

endmodule

// File: rtl/int_to_fp_seq.sv
// Iterative int64 -> double converter, round-to-nearest-even.
// Define INT_TO_FP_INEXACT_EN to add the out_inexact flag port.
module int_to_fp_seq
   import fp_pkg::*;
#(
   parameter int SHIFT_STEP = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [INT_W-1:0] in_int,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_fp
`ifdef INT_TO_FP_INEXACT_EN
   ,
   output logic             out_inexact
`endif
);

   localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_EXP_BIAS + INT_W - 1);

   state_e            state_q, state_d;
   logic              sign_q, sign_d;
   logic [INT_W-1:0]  mag_q, mag_d;
   logic [6:0]        shcnt_q, shcnt_d;
   logic [FP_W-1:0]   fp_q, fp_d;

   logic              guard;
   logic              sticky;
   logic              rnd_up;
   logic [FP_FRAC_W:0]  frac_rnd;
   logic [FP_EXP_W-1:0] exp_rnd;
   logic [FP_W-1:0]     fp_pack;

`ifdef INT_TO_FP_INEXACT_EN
   logic inx_q, inx_d;
`endif

   // mag_q is normalized (bit 63 set) whenever the FSM is in ROUND
   assign guard    = mag_q[10];
   assign sticky   = |mag_q[9:0];
   assign rnd_up   = guard & (sticky | mag_q[11]);
   assign frac_rnd = {1'b0, mag_q[62:11]} + (FP_FRAC_W+1)'(rnd_up);
   assign exp_rnd  = EXP_TOP - {4'b0, shcnt_q}
                   + FP_EXP_W'(frac_rnd[FP_FRAC_W]);

   fp_composer u_composer (
      .sign_i (sign_q),
      .exp_i  (exp_rnd),
      .frac_i (frac_rnd[FP_FRAC_W-1:0]),
      .fp_o   (fp_pack)
   );

   always_comb begin
      state_d = state_q;
      sign_d  = sign_q;
      mag_d   = mag_q;
      shcnt_d = shcnt_q;
      fp_d    = fp_q;
`ifdef INT_TO_FP_INEXACT_EN
      inx_d   = inx_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               sign_d  = in_int[INT_W-1];
               mag_d   = in_int[INT_W-1] ? (~in_int + 64'd1) : in_int;
               shcnt_d = '0;
               if (in_int == '0) begin
                  fp_d    = '0;
`ifdef INT_TO_FP_INEXACT_EN
                  inx_d   = 1'b0;
`endif
                  state_d = DONE;
               end else begin
                  state_d = NORM;
               end
            end
         end
         NORM: begin
            if (mag_q[INT_W-1 -: SHIFT_STEP] == '0) begin
               mag_d   = mag_q << SHIFT_STEP;
               shcnt_d = shcnt_q + 7'(SHIFT_STEP);
            end else if (!mag_q[INT_W-1]) begin
               mag_d   = mag_q << 1;
               shcnt_d = shcnt_q + 7'd1;
            end else begin
               state_d = ROUND;
            end
         end
         ROUND: begin
            fp_d    = fp_pack;
`ifdef INT_TO_FP_INEXACT_EN
            inx_d   = guard | sticky;
`endif
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sign_q  <= 1'b0;
         mag_q   <= '0;
         shcnt_q <= '0;
         fp_q    <= '0;
`ifdef INT_TO_FP_INEXACT_EN
         inx_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sign_q  <= sign_d;
         mag_q   <= mag_d;
         shcnt_q <= shcnt_d;
         fp_q    <= fp_d;
`ifdef INT_TO_FP_INEXACT_EN
         inx_q   <= inx_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_fp    = fp_q;
`ifdef INT_TO_FP_INEXACT_EN
   assign out_inexact = inx_q;
`endif

endmodule

// File: tb/tb_int_to_fp_seq.sv
// Scoreboard bench for int_to_fp_seq: directed vectors, backpressure,
// mid-conversion reset, random and back-to-back traffic.
module tb_int_to_fp_seq;

   localparam int SS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] in_int;
   logic        in_ready;
   logic        out_valid;
   logic [63:0] out_fp;
`ifdef INT_TO_FP_INEXACT_EN
   logic        out_inexact;
`endif

   int checks = 0;
   int fails  = 0;

   logic [63:0] exp_q[$];
   int          lat_q[$];
   bit          inx_q[$];

   always #5 clk = ~clk;

   int_to_fp_seq #(.SHIFT_STEP(SS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_fp    (out_fp)
`ifdef INT_TO_FP_INEXACT_EN
      ,
      .out_inexact (out_inexact)
`endif
   );

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] abs64(input logic [63:0] v);
      return v[63] ? (~v + 64'd1) : v;
   endfunction

   function automatic int msb(input logic [63:0] m);
      for (int i = 63; i >= 0; i--) if (m[i]) return i;
      return -1;
   endfunction

   function automatic logic [63:0] model_fp(input logic [63:0] v);
      longint s;
      real    r;
      if (v == 64'd0) return 64'd0;
      s = longint'(v);
      r = real'(s);
      return $realtobits(r);
   endfunction

   function automatic int model_lat(input logic [63:0] v);
      int lz;
      if (v == 64'd0) return 1;
      lz = 63 - msb(abs64(v));
      return 3 + lz / SS + lz % SS;
   endfunction

   function automatic bit model_inx(input logic [63:0] v);
      logic [63:0] m;
      logic [63:0] mask;
      int p;
      if (v == 64'd0) return 1'b0;
      m = abs64(v);
      p = msb(m);
      if (p <= 52) return 1'b0;
      mask = (64'd1 << (p - 52)) - 64'd1;
      return (m & mask) != 64'd0;
   endfunction

   task automatic send(input logic [63:0] v, input logic [63:0] efp,
                       input int elat, input bit einx);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1;
      in_int   = v;
      for (int i = 0; i < 300; i++) begin
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         fails++;
         $display("FAIL send_accept: in_ready=%b required 1 within 300 cycles", in_ready);
      end
      @(posedge clk);
      exp_q.push_back(efp);
      lat_q.push_back(elat);
      inx_q.push_back(einx);
      #1;
      in_valid = 1'b0;
      in_int   = {$urandom, $urandom};
   endtask

   task automatic recv(output logic [63:0] fp, output bit inx,
                       output int lat, output bit ok);
      lat = 1;
      ok  = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         lat++;
      end
      fp = out_fp;
`ifdef INT_TO_FP_INEXACT_EN
      inx = out_inexact;
`else
      inx = 1'b0;
`endif
   endtask

   task automatic accept_out();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_int    = 64'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_fp !== 64'd0) begin
         fails++;
         $display("FAIL reset_out_fp: got %h want 0", out_fp);
      end
      rst = 1'b0;
   endtask

   task automatic test_vectors();
      logic [63:0] vin [8];
      logic [63:0] vfp [8];
      int          vlat[8];
      bit          vinx[8];
      logic [63:0] fp, e;
      bit          inx, ok, ei;
      int          lat, el;
      vin = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000,
              64'h0020_0000_0000_0001, 64'h0020_0000_0000_0003,
              64'h7FFF_FFFF_FFFF_FFFF, 64'd5};
      vfp = '{64'h3FF0_0000_0000_0000, 64'hBFF0_0000_0000_0000, 64'h0,
              64'hC3E0_0000_0000_0000, 64'h4340_0000_0000_0000,
              64'h4340_0000_0000_0002, 64'h43E0_0000_0000_0000,
              64'h4014_0000_0000_0000};
      vlat = '{17, 17, 1, 3, 6, 6, 4, 15};
      vinx = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int k = 0; k < 8; k++) begin
         send(vin[k], vfp[k], vlat[k], vinx[k]);
         recv(fp, inx, lat, ok);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         ei = inx_q.pop_front();
         checks++;
         if (!ok || fp !== e) begin
            fails++;
            $display("FAIL vec%0d_fp: in=%h got %h want %h (valid=%b)", k, vin[k], fp, e, ok);
         end
         checks++;
         if (lat != el) begin
            fails++;
            $display("FAIL vec%0d_latency: got %0d want %0d", k, lat, el);
         end
`ifdef INT_TO_FP_INEXACT_EN
         checks++;
         if (inx !== ei) begin
            fails++;
            $display("FAIL vec%0d_inexact: got %b want %b", k, inx, ei);
         end
`endif
         accept_out();
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] fp, e;
      bit          inx, ok, ei;
      int          lat, el;
      send(64'd3, 64'h4008_0000_0000_0000, model_lat(64'd3), 1'b0);
      recv(fp, inx, lat, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      ei = inx_q.pop_front();
      checks++;
      if (!ok || fp !== e) begin
         fails++;
         $display("FAIL bp_fp: got %h want %h (valid=%b)", fp, e, ok);
      end
      in_valid = 1'b1;
      in_int   = 64'd42;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_fp !== e || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold%0d: valid=%b fp=%h rdy=%b want 1 %h 0",
                     c, out_valid, out_fp, in_ready, e);
         end
      end
      in_valid = 1'b0;
      accept_out();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: rdy=%b valid=%b want 1 0", in_ready, out_valid);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL bp_ignored: rdy=%b valid=%b want 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_norm();
      logic [63:0] fp, e;
      bit          inx, ok, ei, seen;
      int          lat, el;
      send(64'd1, 64'h3FF0_0000_0000_0000, 17, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_q.delete();
      lat_q.delete();
      inx_q.delete();
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_fp !== 64'd0) begin
         fails++;
         $display("FAIL rst_mid: rdy=%b valid=%b fp=%h want 1 0 0",
                  in_ready, out_valid, out_fp);
      end
      seen = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         fails++;
         $display("FAIL rst_no_emit: out_valid seen=1 want 0");
      end
      send(64'd7, 64'h401C_0000_0000_0000, 15, 1'b0);
      recv(fp, inx, lat, ok);
      e  = exp_q.pop_front();
      el = lat_q.pop_front();
      ei = inx_q.pop_front();
      checks++;
      if (!ok || fp !== e || lat != el) begin
         fails++;
         $display("FAIL rst_after: fp=%h lat=%0d want %h %0d", fp, lat, e, el);
      end
      accept_out();
   endtask

   task automatic test_random();
      logic [63:0] v, fp, e;
      bit          inx, ok, ei;
      int          lat, el;
      for (int k = 0; k < 40; k++) begin
         v = {$urandom, $urandom} >> $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) v = ~v + 64'd1;
         send(v, model_fp(v), model_lat(v), model_inx(v));
         recv(fp, inx, lat, ok);
         e  = exp_q.pop_front();
         el = lat_q.pop_front();
         ei = inx_q.pop_front();
         checks++;
         if (!ok || fp !== e || lat != el) begin
            fails++;
            $display("FAIL rand%0d: in=%h fp=%h lat=%0d want %h %0d",
                     k, v, fp, lat, e, el);
         end
`ifdef INT_TO_FP_INEXACT_EN
         checks++;
         if (inx !== ei) begin
            fails++;
            $display("FAIL rand%0d_inexact: got %b want %b", k, inx, ei);
         end
`endif
         accept_out();
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] vals[6];
      vals = '{64'd255, 64'hFFFF_FFFF_FFFF_FF00, 64'd0,
               64'h0000_0001_0000_0001, 64'h1234_5678_9ABC_DEF1, 64'd2};
      out_ready = 1'b1;
      fork
         begin
            for (int k = 0; k < 6; k++)
               send(vals[k], model_fp(vals[k]), model_lat(vals[k]),
                    model_inx(vals[k]));
         end
         begin
            logic [63:0] fp, e;
            bit          inx, ok;
            int          lat;
            for (int k = 0; k < 6; k++) begin
               recv(fp, inx, lat, ok);
               checks++;
               if (!ok || exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL b2b%0d: no output (valid=%b queue=%0d)",
                           k, ok, exp_q.size());
               end else begin
                  e = exp_q.pop_front();
                  void'(lat_q.pop_front());
                  void'(inx_q.pop_front());
                  if (fp !== e) begin
                     fails++;
                     $display("FAIL b2b%0d: got %h want %h", k, fp, e);
                  end
               end
               @(posedge clk);
            end
         end
      join
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_backpressure();
      test_reset_mid_norm();
      test_random();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
